// File: rtl/sprite_pkg.sv
// sprite_pkg
// Shared types and constants for the sprite BRAM arbiter.
//   arb_state_t         : arbiter grant state (idle / read / write)
//   STALL_W             : width of the saturating write-stall counter
//   DEFAULT_RAM_LATENCY : BRAM read latency (2 = HIGH_PERFORMANCE output register)
package sprite_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_WRITE
  } arb_state_t;

  localparam int STALL_W             = 16;
  localparam int DEFAULT_RAM_LATENCY = 2;

endpackage

// File: rtl/sprite_valid_pipe.sv
// sprite_valid_pipe
// Reset-clearable 1-bit delay line. Carries the read-request flag alongside
// the BRAM read so rd_valid lines up with the returned data.
// Ports:
//   pixel_clk_in : clock, rising edge
//   rst_n_in     : asynchronous active-low reset, clears every stage
//   din          : bit entering the line
//   dout         : din delayed by DEPTH cycles
module sprite_valid_pipe #(
  parameter int DEPTH = 3
) (
  input  logic pixel_clk_in,
  input  logic rst_n_in,
  input  logic din,
  output logic dout
);

  logic [DEPTH-1:0] sr;

  generate
    if (DEPTH == 1) begin : g_single
      always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
        if (!rst_n_in) sr <= '0;
        else           sr <= din;
      end
    end else begin : g_multi
      always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
        if (!rst_n_in) sr <= '0;
        else           sr <= {sr[DEPTH-2:0], din};
      end
    end
  endgenerate

  assign dout = sr[DEPTH-1];

endmodule

// File: rtl/sprite_mem_arbiter.sv
// sprite_mem_arbiter
// Shares one single-port, read-first sprite BRAM between the pixel read
// pipeline (never stalled) and an image loader (uses leftover cycles).
// Read latency seen by the pixel pipeline is fixed at RD_LAT = 1 + RAM_LATENCY.
//
// Optional build macro: SPRITE_ARB_VBLANK_ONLY_EN
//   defined     : writes only accepted while vblank_in is high
//   not defined : writes accepted in any cycle without a read
//
// Ports:
//   pixel_clk_in, rst_n_in     : clock (rising edge), async active-low reset
//   rd_req_in, rd_addr_in      : pixel read request / address
//   rd_data_out, rd_valid_out  : read data (BRAM passthrough) and its valid flag
//   wr_valid_in, wr_ready_out  : loader handshake
//   wr_addr_in, wr_data_in     : loader write address / data
//   vblank_in                  : vertical blanking from video timing
//   load_done_out              : pulse after the last-address write is accepted
//   wr_stall_out               : saturating count of refused write cycles
//   ram_addr_out, ram_din_out, ram_we_out : registered BRAM controls
//   ram_dout_in                : BRAM read data
//
// state   | meaning
// S_IDLE  | no BRAM access this cycle, address held
// S_READ  | BRAM read of the pixel address in flight
// S_WRITE | BRAM write of the loader word in progress (drives ram_we_out)
module sprite_mem_arbiter
  import sprite_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int DEPTH       = 65536,
  parameter int RAM_LATENCY = DEFAULT_RAM_LATENCY,
  localparam int ADDR_W     = $clog2(DEPTH)
) (
  input  logic                pixel_clk_in,
  input  logic                rst_n_in,
  input  logic                rd_req_in,
  input  logic [ADDR_W-1:0]   rd_addr_in,
  output logic [DATA_W-1:0]   rd_data_out,
  output logic                rd_valid_out,
  input  logic                wr_valid_in,
  output logic                wr_ready_out,
  input  logic [ADDR_W-1:0]   wr_addr_in,
  input  logic [DATA_W-1:0]   wr_data_in,
  input  logic                vblank_in,
  output logic                load_done_out,
  output logic [STALL_W-1:0]  wr_stall_out,
  output logic [ADDR_W-1:0]   ram_addr_out,
  output logic [DATA_W-1:0]   ram_din_out,
  output logic                ram_we_out,
  input  logic [DATA_W-1:0]   ram_dout_in
);

  localparam int                RD_LAT    = 1 + RAM_LATENCY;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  arb_state_t         state_q, state_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0]  din_q, din_d;
  logic               write_window;
  logic               wr_accept;
  logic               load_done_q;
  logic [STALL_W-1:0] stall_q;

`ifdef SPRITE_ARB_VBLANK_ONLY_EN
  assign write_window = vblank_in;
`else
  // vblank_in has no effect in this build; OR-ing it in keeps the port live.
  assign write_window = 1'b1 | vblank_in;
`endif

  assign wr_ready_out = !rd_req_in && write_window;
  assign wr_accept    = wr_valid_in && wr_ready_out;

  always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      din_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
    end
  end

  always_comb begin
    state_d = S_IDLE;
    addr_d  = addr_q;
    din_d   = din_q;
    if (rd_req_in) begin
      state_d = S_READ;
      addr_d  = rd_addr_in;
    end else if (wr_accept) begin
      state_d = S_WRITE;
      addr_d  = wr_addr_in;
      din_d   = wr_data_in;
    end
  end

  // The write enable is the registered state itself, so reset removes an
  // in-flight write immediately.
  assign ram_we_out   = (state_q == S_WRITE);
  assign ram_addr_out = addr_q;
  assign ram_din_out  = din_q;

  always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      load_done_q <= 1'b0;
      stall_q     <= '0;
    end else begin
      load_done_q <= wr_accept && (wr_addr_in == LAST_ADDR);
      if (wr_valid_in && !wr_ready_out && (stall_q != '1))
        stall_q <= stall_q + STALL_W'(1);
    end
  end

  assign load_done_out = load_done_q;
  assign wr_stall_out  = stall_q;

  sprite_valid_pipe #(
    .DEPTH (RD_LAT)
  ) u_valid_pipe (
    .pixel_clk_in (pixel_clk_in),
    .rst_n_in     (rst_n_in),
    .din          (rd_req_in),
    .dout         (rd_valid_out)
  );

  assign rd_data_out = ram_dout_in;

endmodule
